serializador_entrada: RTL and testbench
=======================================

Name: serializador_entrada

Overview:
Parallel-to-serial stage that sits directly upstream of the sequence detector and drives its serial input x, one bit per clk. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out, then drives a programmable run of 0s. Because the detector returns to its initial state whenever x=0, this guard run cleanly frames consecutive words.

Parameters:
WIDTH, 8, word width in bits (legal 2..32)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
GAP_CYCLES, 2, number of forced x=0 cycles after each word (legal 0..15)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to serialize
load  input  1  data_in valid; accepted when load && ready at a clk edge
ready  output  1  high only in IDLE; block can accept a word
x  output  1  serial bit stream to detector; 0 whenever no data bit is shown
busy  output  1  high in SHIFT and GAP states
last  output  1  high during the cycle x carries the final bit of a word

Behaviour:
- All outputs are registered or decoded from registered state; there is no combinational path from load or data_in to any output.
- Reset (sampled at posedge, takes priority over everything): state=IDLE, shift register=0, bit counter=0, gap counter=0, x=0, ready=1, busy=0, last=0 in the cycle after the edge.
- Reset mid-word: the word is abandoned and is never resumed. x=0 from the next cycle on.
- States:
  - IDLE: x=0, ready=1, busy=0. On load=1, capture data_in into the shift register and go to SHIFT.
  - SHIFT: ready=0, busy=1. x = current output bit. The bit counter runs 0..WIDTH-1 and last=1 when counter==WIDTH-1. After the final bit, go to GAP if GAP_CYCLES>0, else go to IDLE.
  - GAP: x=0, ready=0, busy=1. Stays GAP_CYCLES cycles, then goes to IDLE.
- Timing (for an accept edge E):
  - x shows bit 0 of the shift order during the cycle after E, bit k in cycle E+1+k.
  - last is high in cycle E+WIDTH.
  - ready rises in cycle E+WIDTH+GAP_CYCLES+1.
- Bit order: MSB_FIRST=1 gives data_in[WIDTH-1] down to data_in[0]; MSB_FIRST=0 gives data_in[0] up to data_in[WIDTH-1].
- load while ready=0 is ignored. No buffering, no error flag, and data_in changes in that window have no effect.
- data_in is sampled only at the accept edge. Later changes do not alter the word in flight.
- Minimum zero run between words is GAP_CYCLES+1 cycles, since IDLE also drives 0. Back-to-back words are therefore always separated by at least one 0.
- Counter widths: the bit counter is clog2(WIDTH) bits and the gap counter is 4 bits. Neither counter wraps while in use, and both are cleared on every state entry.
- load held high continuously: a new word is accepted on every IDLE cycle, giving a period of WIDTH+GAP_CYCLES+1 cycles.

Test Plan:
- Reset check: reset=1 for 2 cycles with load=1 and data_in=8'hFF, then released -> x=0, ready=1, busy=0, last=0; no word is accepted during reset.
- Single word, defaults: load data_in=8'b0111_0110 -> x over cycles E+1..E+8 = 0,1,1,1,0,1,1,0; last=1 only at E+8; x=0 at E+9 and E+10; ready=1 at E+11. Driving the detector, y goes high exactly once, at E+5.
- LSB first: MSB_FIRST=0, data_in=8'hA5 -> x = 1,0,1,0,0,1,0,1.
- Back-to-back: load held at 1 with words 8'hFF then 8'h0F, GAP_CYCLES=0 -> x = 1×8, then 0, then 0,0,0,0,1,1,1,1. The single 0 breaks the run of ones.
- Load while busy: pulse load with data_in=8'h00 at cycle E+3 of word 8'hFF -> it is ignored; the output stays 1×8 and ready does not drop again after IDLE is reached.
- Mid-word reset: assert reset at E+4 of 8'hFF -> x=0 from E+5; IDLE with ready=1; the remaining bits are never emitted.

Source files
------------

// File: rtl/serializador_entrada.sv
// serializador_entrada
// ----------------------------------------------------------------------------
// Parallel-to-serial stage feeding the serial input x of a sequence detector.
// A WIDTH-bit word is accepted through a valid/ready handshake, shifted out one
// bit per clk, and followed by GAP_CYCLES forced zeros. Because the detector
// returns to its initial state on x=0, the zero run frames consecutive words.
//
// Handshake: a word is accepted on a rising clk edge where load && ready.
// ready is high only while idle. load while ready=0 is ignored, and nothing
// is buffered.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   reset    in   synchronous, active-high reset (priority over everything)
//   data_in  in   [WIDTH-1:0] parallel word, sampled only at the accept edge
//   load     in   data_in valid
//   ready    out  high in IDLE; a word can be accepted
//   x        out  serial bit stream; 0 whenever no data bit is shown
//   busy     out  high in SHIFT and GAP
//   last     out  high during the cycle x carries the final bit of a word
//
// All outputs decode registered state only; there is no combinational path
// from load or data_in to any output. The FSM state is held in state_q.
// ----------------------------------------------------------------------------
module serializador_entrada #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    // With GAP_CYCLES=0 the GAP state is never entered, so this value is unused.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sr_d      = data_in;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_q == LAST_IDX) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // The output bit always sits at a fixed end of the register;
                    // shift the next bit into that position.
                    if (MSB_FIRST) begin
                        sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sr_d = {1'b0, sr_q[WIDTH-1:1]};
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign last  = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_IDX);
    assign x     = (state_q == ST_SHIFT) ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : 1'b0;

endmodule

// File: tb/tb_serializador_entrada.sv
// Bench for serializador_entrada. Three instances share clk/reset/load/data_in:
//   dut 0: MSB first, GAP_CYCLES=2 (defaults)
//   dut 1: LSB first, GAP_CYCLES=0
//   dut 2: MSB first, GAP_CYCLES=0
// A reference model tracks, per instance, how many edges have passed since
// the word was accepted and derives the expected outputs of every cycle from
// that position. Expectations are queued at each posedge; a monitor pops and
// compares them 1 ns later.
module tb_serializador_entrada;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [N-1:0] ready_w, busy_w, x_w, last_w;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Position of each instance: -1 = idle, p>=1 = p-th cycle after accept.
    int           pos  [N] = '{-1, -1, -1};
    logic [W-1:0] word [N];

    logic [4*N-1:0] exp_q[$];

    // ------------------------------------------------------------ clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUTs
    serializador_entrada #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_w[0]), .x(x_w[0]), .busy(busy_w[0]), .last(last_w[0])
    );
    serializador_entrada #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_w[1]), .x(x_w[1]), .busy(busy_w[1]), .last(last_w[1])
    );
    serializador_entrada #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_w[2]), .x(x_w[2]), .busy(busy_w[2]), .last(last_w[2])
    );

    function automatic bit cfg_msb(input int i);
        return (i != 1);
    endfunction

    function automatic int cfg_gap(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Expected {ready, busy, x, last} for an instance at position p.
    function automatic logic [3:0] expect_out(input int i, input int p, input logic [W-1:0] wd);
        int   k;
        logic b;
        if (p < 0) return 4'b1000;
        if (p <= W) begin
            k = p - 1;
            b = cfg_msb(i) ? wd[W-1-k] : wd[k];
            return {1'b0, 1'b1, b, (p == W)};
        end
        return 4'b0100;
    endfunction

    // ------------------------------------------------------------ model
    always @(posedge clk) begin
        logic [4*N-1:0] e;
        int             np;
        logic [W-1:0]   nw;
        e = '0;
        for (int i = 0; i < N; i++) begin
            np = pos[i];
            nw = word[i];
            if (reset) begin
                np = -1;
            end else if (np < 0) begin
                if (load) begin
                    np = 1;
                    nw = data_in;
                end
            end else begin
                np = np + 1;
                if (np > W + cfg_gap(i)) np = -1;
            end
            pos[i]  <= np;
            word[i] <= nw;
            e[4*i +: 4] = expect_out(i, np, nw);
        end
        exp_q.push_back(e);
        cycle <= cycle + 1;
    end

    // ------------------------------------------------------------ monitor
    always @(posedge clk) begin
        logic [4*N-1:0] e;
        logic [3:0]     act;
        #1;
        if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL no_expectation cycle=%0d", cycle);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
                act   = {ready_w[i], busy_w[i], x_w[i], last_w[i]};
                total = total + 1;
                if (act !== e[4*i +: 4]) begin
                    bad = bad + 1;
                    $display("FAIL dut%0d_outputs cycle=%0d got{ready,busy,x,last}=%b want=%b",
                             i, cycle, act, e[4*i +: 4]);
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic idle(input int n);
        load = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        load    = 1'b1;
        data_in = d;
        @(negedge clk);
        load    = 1'b0;
    endtask

    initial begin
        // Reset with load high: nothing may be accepted.
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3);

        // Single word, and LSB-first word.
        send(8'b0111_0110);
        idle(14);
        send(8'hA5);
        idle(14);

        // Back-to-back with load held high; data changes after first accept.
        load    = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        data_in = 8'h0F;
        repeat (24) @(negedge clk);
        idle(14);

        // Load pulse while busy must be ignored.
        send(8'hFF);
        repeat (2) @(negedge clk);
        send(8'h00);
        idle(14);

        // Reset in the middle of a word.
        send(8'hFF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(14);

        // Randomized traffic with occasional resets.
        repeat (800) begin
            load    = ($urandom_range(0, 2) == 0);
            data_in = W'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
